// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: owns the two-player BCD scores, picks the active text
// overlays and freezes/relaunches the ball between points and games.
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 11,
    parameter int DELAY_TICKS = 120,
    parameter int TMR_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       p1_score,
    input  logic       p2_score,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] text_en,
    output logic       ball_still,
    output logic       ball_launch,
    output logic [1:0] winner,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [7:0]       WIN_BCD   = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam logic [TMR_W-1:0] DELAY_LD  = TMR_W'(DELAY_TICKS);

    // Scores are held as {tens, ones}; 99 saturates.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_btn_q;
    logic [7:0]       r_p1;
    logic [7:0]       r_p2;
    logic [1:0]       r_winner;
    logic [3:0]       r_text_en;
    logic             r_ball_still;
    logic             r_ball_launch;

    state_t           w_state_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [7:0]       w_p1_nxt;
    logic [7:0]       w_p2_nxt;
    logic [1:0]       w_winner_nxt;
    logic [3:0]       w_text_nxt;
    logic             w_still_nxt;
    logic             w_launch_nxt;
    logic             w_start_edge;
    logic [7:0]       w_p1_new;
    logic [7:0]       w_p2_new;
    logic             w_p1_win;
    logic             w_p2_win;
    logic             w_expired;

    assign w_start_edge = btn_start & ~r_btn_q;
    assign w_p1_new     = p1_score ? bcd_inc(r_p1) : r_p1;
    assign w_p2_new     = p2_score ? bcd_inc(r_p2) : r_p2;
    assign w_p1_win     = (w_p1_new == WIN_BCD);
    assign w_p2_win     = (w_p2_new == WIN_BCD);
    // A zero timer can only appear after a missed load; treat it as expired.
    assign w_expired    = (r_timer <= TMR_W'(1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_p1_nxt     = r_p1;
        w_p2_nxt     = r_p2;
        w_winner_nxt = r_winner;
        w_launch_nxt = 1'b0;

        unique case (r_state)
            NEWGAME: begin
                if (w_start_edge) begin
                    w_p1_nxt     = 8'h00;
                    w_p2_nxt     = 8'h00;
                    w_winner_nxt = 2'b00;
                    w_state_nxt  = PLAY;
                    w_launch_nxt = 1'b1;
                end
            end
            PLAY: begin
                if (p1_score || p2_score) begin
                    w_p1_nxt    = w_p1_new;
                    w_p2_nxt    = w_p2_new;
                    w_timer_nxt = DELAY_LD;
                    if (w_p1_win || w_p2_win) begin
                        w_state_nxt  = OVER;
                        w_winner_nxt = {w_p2_win, w_p1_win};
                    end else begin
                        w_state_nxt = NEWBALL;
                    end
                end
            end
            NEWBALL, OVER: begin
                if (tick) begin
                    if (w_expired) begin
                        w_timer_nxt = '0;
                        if (r_state == NEWBALL) begin
                            w_state_nxt  = PLAY;
                            w_launch_nxt = 1'b1;
                        end else begin
                            w_state_nxt = NEWGAME;
                        end
                    end else begin
                        w_timer_nxt = r_timer - TMR_W'(1);
                    end
                end
            end
            default: w_state_nxt = NEWGAME;
        endcase

        // Overlay and freeze outputs follow the state being entered.
        w_text_nxt  = 4'b1110;
        w_still_nxt = 1'b1;
        unique case (w_state_nxt)
            PLAY:    begin w_text_nxt = 4'b1000; w_still_nxt = 1'b0; end
            NEWBALL: begin w_text_nxt = 4'b1000; w_still_nxt = 1'b1; end
            OVER:    begin w_text_nxt = 4'b1001; w_still_nxt = 1'b1; end
            default: begin w_text_nxt = 4'b1110; w_still_nxt = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, sampled only on the clock edge; sequential state uses non-blocking assignments.
        if (!reset_n) begin
            r_state       <= NEWGAME;
            r_timer       <= '0;
            r_btn_q       <= 1'b1;
            r_p1          <= 8'h00;
            r_p2          <= 8'h00;
            r_winner      <= 2'b00;
            r_text_en     <= 4'b1110;
            r_ball_still  <= 1'b1;
            r_ball_launch <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_btn_q       <= btn_start;
            r_p1          <= w_p1_nxt;
            r_p2          <= w_p2_nxt;
            r_winner      <= w_winner_nxt;
            r_text_en     <= w_text_nxt;
            r_ball_still  <= w_still_nxt;
            r_ball_launch <= w_launch_nxt;
        end
    end

    assign dig0        = r_p1[3:0];
    assign dig1        = r_p1[7:4];
    assign dig2        = r_p2[3:0];
    assign dig3        = r_p2[7:4];
    assign text_en     = r_text_en;
    assign ball_still  = r_ball_still;
    assign ball_launch = r_ball_launch;
    assign winner      = r_winner;
    assign state       = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: the stimulus pushes hand-derived output
// snapshots, a negedge monitor pops and compares them against the DUT.
module tb_pong_game_ctrl;

    localparam logic [1:0] S_NEWGAME = 2'd0;
    localparam logic [1:0] S_PLAY    = 2'd1;
    localparam logic [1:0] S_NEWBALL = 2'd2;
    localparam logic [1:0] S_OVER    = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       btn_start;
    logic       p1_score;
    logic       p2_score;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [3:0] text_en;
    logic       ball_still;
    logic       ball_launch;
    logic [1:0] winner;
    logic [1:0] state;

    typedef struct {
        string       name;
        logic [25:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int       n_pass  = 0;
    int       n_total = 0;

    // Hand-tracked expectations: scores as {tens, ones} BCD bytes.
    logic [7:0] e_p1  = 8'h00;
    logic [7:0] e_p2  = 8'h00;
    logic [1:0] e_win = 2'b00;

    logic [7:0] bcd_tab [0:11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                   8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11};

    pong_game_ctrl #(
        .WIN_SCORE  (11),
        .DELAY_TICKS(3),
        .TMR_W      (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .btn_start  (btn_start),
        .p1_score   (p1_score),
        .p2_score   (p2_score),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .text_en    (text_en),
        .ball_still (ball_still),
        .ball_launch(ball_launch),
        .winner     (winner),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got dig=%h text=%b still=%b launch=%b win=%b st=%0d, want dig=%h text=%b still=%b launch=%b win=%b st=%0d",
                     name, act[25:10], act[9:6], act[5], act[4], act[3:2], act[1:0],
                     exp[25:10], exp[9:6], exp[5], exp[4], exp[3:2], exp[1:0]);
    endtask

    // Monitor: every registered output is valid each cycle, so any pending
    // expectation is compared on the next falling edge.
    always @(negedge clk) begin
        sb_item_t it;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            check(it.name, {dig3, dig2, dig1, dig0, text_en, ball_still, ball_launch, winner, state}, it.exp);
        end
    end

    task automatic push_exp(input string name, input logic [1:0] st, input logic launch);
        logic [3:0] te;
        logic       still;
        case (st)
            S_NEWGAME: begin te = 4'b1110; still = 1'b1; end
            S_PLAY:    begin te = 4'b1000; still = 1'b0; end
            S_NEWBALL: begin te = 4'b1000; still = 1'b1; end
            default:   begin te = 4'b1001; still = 1'b1; end
        endcase
        sb.push_back('{name, {e_p2, e_p1, te, still, launch, e_win, st}});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic point(input logic a, input logic b);
        p1_score = a;
        p2_score = b;
        cyc();
        p1_score = 1'b0;
        p2_score = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    // Three ticks from NEWBALL: the third relaunches the ball.
    task automatic serve(input string name);
        do_tick();
        do_tick();
        tick = 1'b1;
        cyc();
        push_exp({name, "_launch"}, S_PLAY, 1'b1);
        tick = 1'b0;
        cyc();
        push_exp({name, "_play"}, S_PLAY, 1'b0);
    endtask

    task automatic game_over_wait(input string name);
        do_tick();
        do_tick();
        tick = 1'b1;
        cyc();
        push_exp(name, S_NEWGAME, 1'b0);
        tick = 1'b0;
        cyc();
    endtask

    task automatic start_game(input string name);
        btn_start = 1'b0;
        cyc();
        btn_start = 1'b1;
        cyc();
        e_p1 = 8'h00; e_p2 = 8'h00; e_win = 2'b00;
        push_exp({name, "_launch"}, S_PLAY, 1'b1);
        cyc();
        push_exp({name, "_play"}, S_PLAY, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d checks pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; btn_start = 1'b1; tick = 1'b0; p1_score = 1'b0; p2_score = 1'b0;

        // 1. Reset with button held; held button must not start a game.
        cyc(); cyc();
        push_exp("reset", S_NEWGAME, 1'b0);
        reset_n = 1'b1;
        cyc(); cyc();
        push_exp("held_btn", S_NEWGAME, 1'b0);
        start_game("start1");

        // 2. Delay timing: two ticks are not enough, the third relaunches.
        point(1'b1, 1'b0);
        e_p1 = 8'h01;
        push_exp("p1_point", S_NEWBALL, 1'b0);
        do_tick();
        do_tick();
        push_exp("two_ticks", S_NEWBALL, 1'b0);
        tick = 1'b1;
        cyc();
        push_exp("third_tick", S_PLAY, 1'b1);
        tick = 1'b0;
        cyc();
        push_exp("launch_once", S_PLAY, 1'b0);

        // 3. Ten P2 points carry into the tens digit.
        for (int i = 1; i <= 10; i++) begin
            point(1'b0, 1'b1);
            e_p2 = bcd_tab[i];
            push_exp($sformatf("p2_pt%0d", i), S_NEWBALL, 1'b0);
            serve($sformatf("p2_srv%0d", i));
        end

        // 4. P1 to 10, then the winning point.
        for (int i = 2; i <= 10; i++) begin
            point(1'b1, 1'b0);
            e_p1 = bcd_tab[i];
            push_exp($sformatf("p1_pt%0d", i), S_NEWBALL, 1'b0);
            serve($sformatf("p1_srv%0d", i));
        end
        point(1'b1, 1'b0);
        e_p1 = 8'h11; e_win = 2'b01;
        push_exp("p1_wins", S_OVER, 1'b0);
        point(1'b1, 1'b1);
        push_exp("over_ignores", S_OVER, 1'b0);
        game_over_wait("over_expire");
        start_game("start2");

        // 5a. Simultaneous points up to 11/11.
        for (int i = 1; i <= 10; i++) begin
            point(1'b1, 1'b1);
            e_p1 = bcd_tab[i]; e_p2 = bcd_tab[i];
            push_exp($sformatf("both_pt%0d", i), S_NEWBALL, 1'b0);
            serve($sformatf("both_srv%0d", i));
        end
        point(1'b1, 1'b1);
        e_p1 = 8'h11; e_p2 = 8'h11; e_win = 2'b11;
        push_exp("both_win", S_OVER, 1'b0);
        game_over_wait("over2_expire");
        start_game("start3");

        // 5b. Same-cycle events at 3/4 give 4/5 and a new ball.
        point(1'b0, 1'b1);
        e_p2 = 8'h01;
        push_exp("p2_lead", S_NEWBALL, 1'b0);
        serve("lead_srv");
        for (int i = 1; i <= 4; i++) begin
            point(1'b1, 1'b1);
            e_p1 = bcd_tab[i]; e_p2 = bcd_tab[i+1];
            push_exp($sformatf("both_b_pt%0d", i), S_NEWBALL, 1'b0);
            if (i < 4) serve($sformatf("both_b_srv%0d", i));
        end

        // 6. Points in NEWBALL are dropped; reset aborts mid-delay.
        point(1'b1, 1'b0);
        push_exp("newball_ignores", S_NEWBALL, 1'b0);
        do_tick();
        push_exp("timer_at_2", S_NEWBALL, 1'b0);
        reset_n = 1'b0;
        cyc();
        e_p1 = 8'h00; e_p2 = 8'h00; e_win = 2'b00;
        push_exp("abort_reset", S_NEWGAME, 1'b0);
        reset_n = 1'b1;
        cyc();
        push_exp("after_abort", S_NEWGAME, 1'b0);

        cyc(); cyc();
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d checks left unconsumed, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
